// File: rtl/div_pkg.sv
// Shared definitions for the shift-subtract divider.
//   DIV_N_DEFAULT  default operand width
//   div_state_t    controller state encoding
//   div_cnt_width  width of the iteration counter for a given operand width
package div_pkg;

    localparam int unsigned DIV_N_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Counter must be able to hold 0 .. N.
    function automatic int unsigned div_cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div_ctrl.sv
// Sequencer for the shift-subtract divider: owns the state register and the
// iteration counter and decodes the datapath strobes.
//   i_clk        clock, rising edge
//   i_reset      synchronous reset, active low
//   i_start      load operands / restart
//   i_d_zero     stored divisor is zero
//   o_load       capture operands this edge
//   o_iter       perform one shift-subtract iteration this edge
//   o_dbz_fix    write the divide-by-zero result this edge
//   o_set_ready  result becomes valid after this edge
module div_ctrl
    import div_pkg::*;
#(
    parameter int unsigned N = DIV_N_DEFAULT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_start,
    input  logic i_d_zero,
    output logic o_load,
    output logic o_iter,
    output logic o_dbz_fix,
    output logic o_set_ready
);

    localparam int unsigned CW = div_cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    div_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          w_busy_run;

    // Strobes are gated by reset and start so that reset beats start and
    // start beats any iteration in progress.
    always_comb begin
        w_busy_run  = i_reset && !i_start && (r_state == BUSY);
        o_load      = i_reset && i_start;
        o_iter      = w_busy_run && !i_d_zero;
        o_dbz_fix   = w_busy_run && i_d_zero;
        o_set_ready = o_dbz_fix || (o_iter && (r_cnt == LAST));
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (i_start) begin
            r_state <= BUSY;
            r_cnt   <= '0;
        end else if (o_dbz_fix) begin
            r_state <= DONE;
        end else if (o_iter) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
                r_state <= DONE;
            end
        end
    end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
//   clk          clock, rising edge
//   reset        synchronous reset, active low
//   start        capture a/b and (re)start
//   a, b         dividend, divisor (N bits, unsigned)
//   q, r         quotient, remainder (valid while ready)
//   ready        result valid (registered)
//   div_by_zero  last started operation had b == 0 (valid while ready)
module shift_sub_divider
    import div_pkg::*;
#(
    parameter int unsigned N = DIV_N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         ready,
    output logic         div_by_zero
);

    logic [N-1:0] r_div;
    logic [N-1:0] r_quo;
    // The partial remainder is N+1 bits wide in the algorithm, but its top
    // bit is always 0 between iterations (remainder < divisor), so only the
    // low N bits are stored and the full width is rebuilt for the subtract.
    logic [N-1:0] r_rem;
    logic         r_ready;
    logic         r_dbz;

    logic         w_load;
    logic         w_iter;
    logic         w_dbz_fix;
    logic         w_set_ready;
    logic         w_d_zero;
    logic [N:0]   w_shift;
    logic [N:0]   w_trial;

    assign w_d_zero = (r_div == '0);
    assign w_shift  = {r_rem, r_quo[N-1]};
    assign w_trial  = w_shift - {1'b0, r_div};

    div_ctrl #(
        .N (N)
    ) u_ctrl (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_d_zero    (w_d_zero),
        .o_load      (w_load),
        .o_iter      (w_iter),
        .o_dbz_fix   (w_dbz_fix),
        .o_set_ready (w_set_ready)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_ready <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            if (w_load) begin
                r_div   <= b;
                r_quo   <= a;
                r_rem   <= '0;
                r_ready <= 1'b0;
                r_dbz   <= (b == '0);
            end else if (w_iter) begin
                // Trial MSB clear means the shifted remainder covered the divisor.
                if (!w_trial[N]) begin
                    r_rem <= w_trial[N-1:0];
                    r_quo <= {r_quo[N-2:0], 1'b1};
                end else begin
                    r_rem <= w_shift[N-1:0];
                    r_quo <= {r_quo[N-2:0], 1'b0};
                end
            end else if (w_dbz_fix) begin
                r_quo <= '1;
                r_rem <= r_quo;
            end
            if (w_set_ready) begin
                r_ready <= 1'b1;
            end
        end
    end

    assign q           = r_quo;
    assign r           = r_rem;
    assign ready       = r_ready;
    assign div_by_zero = r_dbz;

endmodule
